fun: RTL and testbench
======================

FUN -- requirements
Module: fun

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named clk_i and rst_i.
REQ-002 The ports SHALL be, one per line (name  direction  width  meaning):
- clk_i  input  1  clock; all state updates on the rising edge
- rst_i  input  1  synchronous active-high reset
- start_i  input  1  request to begin an operation; level-sampled in IDLE
- a_bi  input  8  unsigned dividend
- b_bi  input  8  unsigned divisor
- busy_o  output  1  high while an operation is in progress
- y_bo  output  8  unsigned result register
REQ-003 The block SHALL have no parameters; all widths SHALL be fixed at 8 bits.

Function
REQ-004 The block SHALL compute y = floor(a / b) on unsigned 8-bit operands.
- Implementation: sequential restoring division, one quotient bit per clock, MSB first.
REQ-005 The state machine SHALL have two states, IDLE and WORK.
REQ-006 In IDLE with start_i=1 at a rising edge, the block SHALL:
- capture a_bi and b_bi into internal registers
- clear the partial remainder
- set the bit counter to 7
- assert busy_o
- enter WORK.
REQ-007 In IDLE with start_i=0, state and outputs SHALL hold.
REQ-008 Each WORK cycle SHALL:
- shift the next dividend bit into the remainder
- subtract the divisor if remainder >= divisor
- set the corresponding quotient bit
- decrement the counter.
REQ-009 On the WORK cycle that handles bit 0 (the 8th WORK edge), the block SHALL:
- load the final quotient into y_bo
- deassert busy_o
- return to IDLE.
REQ-010 Latency SHALL be 9 rising edges from the edge sampling start_i=1 until y_bo is valid and busy_o is low; this is 1 capture edge plus 8 WORK edges.
REQ-011 y_bo SHALL change only at operation completion or reset, and SHALL hold the last result otherwise, including throughout WORK.
REQ-012 start_i SHALL be ignored while busy_o=1.
REQ-013 Operand changes on a_bi and b_bi during WORK SHALL NOT affect the running operation.
REQ-014 If start_i stays high continuously, the block SHALL re-start on the first IDLE edge after completion.
- Each repeated operation yields the same y_bo for unchanged operands, so y_bo is stable.
REQ-015 Divide by zero (b=0) SHALL produce y_bo=8'hFF with normal latency and no error flag.
REQ-016 Internal remainder SHALL be 9 bits wide so that the compare/subtract never overflows.

Reset
REQ-017 While rst_i=1 at a rising edge, the block SHALL:
- force state to IDLE
- set busy_o=0
- set y_bo=8'h00
- clear all internal operand, remainder and counter registers.
REQ-018 Reset asserted mid-operation SHALL abort the operation.
- No partial result SHALL reach y_bo.
REQ-019 When rst_i=1 and start_i=1 coincide, reset SHALL win.
REQ-020 Start SHALL be sampled normally on the first edge with rst_i=0.

Verification
REQ-021 The bench SHALL cover the following directed scenarios:
- Reset, then a=23, b=8, start held high -> busy_o=1 for 9 edges, then y_bo=2 within 10 clock periods of reset release; y_bo stays 2 while start remains high.
- a=255, b=1 -> y_bo=255; a=7, b=9 -> y_bo=0; a=200, b=200 -> y_bo=1.
- a=37, b=0 -> y_bo=8'hFF after 9 edges.
- Change a_bi and b_bi during WORK -> result matches the operands captured at start.
- Assert rst_i at WORK edge 4 -> busy_o=0, y_bo=0 on the next edge; a fresh start then completes correctly.
- Exhaustive sweep of a and b over 0..15 with b>0, one start pulse per pair, waiting for busy_o low -> y_bo equals integer a/b.

Source files
------------

// File: rtl/fun.sv
// Sequential 8-bit unsigned restoring divider: y = floor(a / b).
// One quotient bit per clock, MSB first; divide by zero yields 8'hFF.
module fun (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [7:0] a_bi,
  input  logic [7:0] b_bi,
  output logic       busy_o,
  output logic [7:0] y_bo
);

  typedef enum logic {IDLE, WORK} state_e;

  state_e      state_q, state_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic [7:0]  q_q, q_d;
  logic [7:0]  y_q, y_d;
  logic [8:0]  rem_q, rem_d;
  logic [8:0]  rem_sh;
  logic [2:0]  cnt_q, cnt_d;
  logic        qbit;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      q_q     <= '0;
      y_q     <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      q_q     <= q_d;
      y_q     <= y_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
    end
  end

  // The remainder is always below the divisor, so its low 8 bits hold it fully;
  // the 9th bit gives headroom after the shift so the compare never overflows.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    q_d     = q_q;
    y_d     = y_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    rem_sh  = {rem_q[7:0], a_q[cnt_q]};
    qbit    = (rem_sh >= {1'b0, b_q});

    case (state_q)
      IDLE: begin
        if (start_i) begin
          a_d     = a_bi;
          b_d     = b_bi;
          rem_d   = '0;
          q_d     = '0;
          cnt_d   = 3'd7;
          state_d = WORK;
        end
      end
      WORK: begin
        rem_d = qbit ? (rem_sh - {1'b0, b_q}) : rem_sh;
        q_d   = {q_q[6:0], qbit};
        if (cnt_q == 3'd0) begin
          y_d     = {q_q[6:0], qbit};
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
    endcase
  end

  assign busy_o = (state_q == WORK);
  assign y_bo   = y_q;

endmodule

// File: tb/tb_fun.sv
// Scoreboarded bench for the sequential divider: stimulus pushes expected
// quotients, a monitor pops and compares on every busy falling edge.
module tb_fun;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       start_i;
  logic [7:0] a_bi;
  logic [7:0] b_bi;
  logic       busy_o;
  logic [7:0] y_bo;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;
  logic [7:0]  exp_q[$];
  logic        busy_prev = 1'b0;

  fun dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start_i),
    .a_bi    (a_bi),
    .b_bi    (b_bi),
    .busy_o  (busy_o),
    .y_bo    (y_bo)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input int unsigned act, input int unsigned req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
  endtask

  // Monitor: a completed (or reset-aborted) operation shows as busy falling.
  always @(negedge clk_i) begin
    if (busy_prev && !busy_o) begin
      if (exp_q.size() == 0) begin
        check("unexpected_completion", 1, 0);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        check("y_on_completion", y_bo, e);
      end
    end
    busy_prev = busy_o;
  end

  // Counts edges from the capture edge until busy drops (bounded).
  task automatic wait_done(output int unsigned edges);
    edges = 1;
    while (busy_o && edges < 40) begin
      @(posedge clk_i); #1;
      edges++;
    end
    if (busy_o) check("done_timeout", 1, 0);
  endtask

  // One start pulse; optionally scramble operands while WORK is running.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] exp, input bit scramble, input bit chk_lat);
    int unsigned edges;
    @(negedge clk_i);
    a_bi = a; b_bi = b; start_i = 1'b1;
    exp_q.push_back(exp);
    @(posedge clk_i); #1;
    start_i = 1'b0;
    check("busy_after_start", busy_o, 1);
    if (scramble) begin
      a_bi = a ^ 8'hA5;
      b_bi = b + 8'd3;
    end
    wait_done(edges);
    if (chk_lat) check("latency_edges", edges, 9);
  endtask

  initial begin
    int unsigned edges;
    rst_i = 1'b1; start_i = 1'b1; a_bi = 8'd23; b_bi = 8'd8;

    // Reset wins over a coincident start.
    repeat (2) @(posedge clk_i);
    #1;
    check("reset_busy", busy_o, 0);
    check("reset_y", y_bo, 0);

    // Release reset with start held: first op starts on the first free edge.
    @(negedge clk_i);
    rst_i = 1'b0;
    exp_q.push_back(8'd2);
    @(posedge clk_i); #1;
    check("held_start_busy", busy_o, 1);
    check("y_holds_during_work", y_bo, 0);
    wait_done(edges);
    check("held_latency_edges", edges, 9);
    check("held_y_first", y_bo, 2);

    // Start still high: restart on the next IDLE edge, y stays 2 throughout.
    exp_q.push_back(8'd2);
    @(posedge clk_i); #1;
    check("restart_busy", busy_o, 1);
    repeat (4) @(posedge clk_i);
    #1;
    check("y_stable_mid_restart", y_bo, 2);
    while (busy_o && edges < 60) begin
      @(posedge clk_i); #1;
      edges++;
    end
    check("restart_done", busy_o, 0);
    check("held_y_second", y_bo, 2);
    @(negedge clk_i);
    start_i = 1'b0;
    @(posedge clk_i); #1;
    check("idle_after_drop", busy_o, 0);

    // Directed operands, including divide by zero.
    run_op(8'd255, 8'd1,   8'd255, 1'b0, 1'b1);
    run_op(8'd7,   8'd9,   8'd0,   1'b0, 1'b1);
    run_op(8'd200, 8'd200, 8'd1,   1'b0, 1'b1);
    run_op(8'd37,  8'd0,   8'hFF,  1'b0, 1'b1);
    run_op(8'd0,   8'd0,   8'hFF,  1'b0, 1'b1);
    run_op(8'd128, 8'd255, 8'd0,   1'b0, 1'b1);
    run_op(8'd254, 8'd127, 8'd2,   1'b0, 1'b1);

    // Operand changes during WORK must not affect the result.
    run_op(8'd100, 8'd7, 8'd14, 1'b1, 1'b1);
    check("scrambled_y", y_bo, 14);

    // Reset at WORK edge 4 aborts: monitor sees busy fall with y = 0.
    @(negedge clk_i);
    a_bi = 8'd50; b_bi = 8'd5; start_i = 1'b1;
    exp_q.push_back(8'd0);
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    check("abort_busy", busy_o, 0);
    check("abort_y", y_bo, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    run_op(8'd50, 8'd5, 8'd10, 1'b0, 1'b1);

    // Sweep 0..15 / 1..15.
    for (int a = 0; a < 16; a++) begin
      for (int b = 1; b < 16; b++) begin
        run_op(8'(a), 8'(b), 8'(a / b), 1'b0, 1'b0);
      end
    end

    repeat (3) @(posedge clk_i);
    #1;
    check("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
